pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage (IF/ID/EX/MEM/WB) core. It drives the per-stage register enables and flushes, and decides each cycle whether the pipeline advances, stalls or squashes. The causes are load-use and flag-use hazards in ID, taken branches resolved in EX, and multi-cycle data-memory accesses in MEM. It sits beside the decode control logic and consumes its decoded RegWrite/MemToReg/flagWrite/BrTaken signals as registered pipeline fields.

## Interface
Parameters:
- MEM_TIMEOUT, default 15: number of consecutive memory-wait cycles tolerated before a fatal timeout; legal range 2..255.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- id_rn, id_rm  in  5 each  source register indices of the instruction in ID.
- id_rn_used, id_rm_used  in  1 each  the ID instruction reads that source.
- id_flag_use  in  1  the ID instruction reads NZCV (BLT).
- ex_mem_read  in  1  the EX instruction is LDUR.
- ex_rd  in  5  destination index of the EX instruction.
- ex_flag_write  in  1  the EX instruction sets flags (ADDS/SUBS).
- ex_br_taken  in  1  the branch in EX is resolved taken.
- mem_valid  in  1  the MEM stage holds LDUR/STUR awaiting memory.
- mem_ready  in  1  the data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables.
- ifid_flush, idex_flush  out  1 each  load a NOP into IF/ID or ID/EX.
- memwb_bubble  out  1  load a NOP into MEM/WB.
- mem_timeout  out  1  sticky fatal error flag.
- stall_cycles, flush_events  out  32 each  performance counters (see Configuration).

## Operation
- States: RUN, MEM_WAIT, ERR, encoded in 2 bits. The next-state logic is registered; the enables and flushes are Mealy outputs.
- Hazard terms, evaluated combinationally:
  - load_use = ex_mem_read & ex_rd≠31 & ((id_rn_used & id_rn==ex_rd) | (id_rm_used & id_rm==ex_rd)). Register 31 (XZR) never hazards.
  - flag_use = id_flag_use & ex_flag_write.
  - mem_stall = mem_valid & ~mem_ready.
- Priority is mem_stall > ex_br_taken > (load_use | flag_use).
- Output actions:
  - mem_stall (RUN or MEM_WAIT): pc/ifid/idex/exmem_en = 0, memwb_en = 1, memwb_bubble = 1, no flushes.
  - ex_br_taken: all enables 1, ifid_flush = 1, idex_flush = 1. The ID hazard is ignored because that instruction is squashed.
  - load_use | flag_use: pc_en = 0, ifid_en = 0, idex_flush = 1, remaining enables 1. This is exactly one bubble, because the hazard clears once the producer leaves EX.
  - Otherwise all enables 1 and all flushes/bubbles 0.
- State transitions:
  - RUN→MEM_WAIT on mem_stall.
  - MEM_WAIT→RUN on mem_ready. The ready cycle itself is evaluated as RUN with mem_stall = 0, so branch and hazard actions apply that cycle.
  - MEM_WAIT→ERR when mem_stall persists after MEM_TIMEOUT consecutive stalled cycles.
- wait_cnt (8 bits) clears in RUN and increments on each mem_stall cycle. ERR is entered at the edge where wait_cnt==MEM_TIMEOUT-1 and mem_stall is still 1.
- ERR: all enables 0, flushes 0, memwb_bubble = 1, mem_timeout = 1. ERR persists until reset; inputs are ignored.
- Upstream must hold ex_br_taken, ex_rd and the other EX fields stable while EX is frozen.

## Timing
- Outputs are combinational from the state and the current inputs, with no added latency. The stall decision lands in the same cycle as the hazard.
- The load-use/flag penalty is exactly 1 cycle. The taken-branch penalty is 2 squashed instructions.
- Memory wait of N cycles (mem_ready arrives on stall cycle N+1): the pipeline freezes for N cycles and advances in cycle N+1.
- Reset, asynchronous: state = RUN and wait_cnt = 0, counters = 0, mem_timeout = 0. While reset is high, all *_en = 0, ifid_flush = idex_flush = 1 and memwb_bubble = 1.
- Reset asserted mid-MEM_WAIT or in ERR returns the block to RUN on release with no residual stall.

## Configuration
- PIPE_PERF_EN defined: counters are active.
  - stall_cycles increments on every cycle with any stall (load_use, flag_use, or mem_stall), including cycles spent in ERR.
  - flush_events increments once per taken-branch flush.
  - Both counters saturate at 0xFFFFFFFF and are cleared by reset.
- PIPE_PERF_EN undefined: both ports are tied to 0, no counter flops are synthesized, and all other behaviour is identical.

## Test plan
- LDUR X2 in EX (ex_rd=2), ADDS in ID with id_rm=2 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; the next cycle all enables are 1.
- Same pattern but ex_rd=31 -> no stall; the independent case id_rn=3 -> no stall.
- SUBS in EX, BLT in ID -> one bubble. ex_br_taken=1 in the same cycle as a load_use -> ifid_flush=idex_flush=1, pc_en=1, no stall; flush_events +1 when PIPE_PERF_EN is defined.
- mem_valid=1 with mem_ready low for 3 cycles, then high -> 3 frozen cycles with memwb_bubble=1, state MEM_WAIT, then an advance and a return to RUN; stall_cycles=3.
- With MEM_TIMEOUT=4, mem_ready is never asserted -> ERR after 4 stalled cycles, mem_timeout=1 and all enables 0. Asserting reset returns the block to RUN with mem_timeout=0.
- Reset asserted in MEM_WAIT in mid-cycle -> outputs go immediately to the reset values; after release with no hazards, all enables are 1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes from load-use, flag-use,
// taken-branch and memory-wait conditions. Define PIPE_PERF_EN to build the perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rn,
    input  logic [4:0]  id_rm,
    input  logic        id_rn_used,
    input  logic        id_rm_used,
    input  logic        id_flag_use,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_flag_write,
    input  logic        ex_br_taken,
    input  logic        mem_valid,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        memwb_bubble,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_nxt;
    logic       w_load_use;
    logic       w_flag_use;
    logic       w_hazard;
    logic       w_mem_stall;

    // XZR (register 31) is never a real producer, so it cannot hazard.
    assign w_load_use  = ex_mem_read & (ex_rd != 5'd31) &
                         ((id_rn_used & (id_rn == ex_rd)) | (id_rm_used & (id_rm == ex_rd)));
    assign w_flag_use  = id_flag_use & ex_flag_write;
    assign w_hazard    = w_load_use | w_flag_use;
    assign w_mem_stall = mem_valid & ~mem_ready;
    assign mem_timeout = (r_state == ERR);

    // State and wait counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Next-state and Mealy stage-control outputs.
    always_comb begin
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        idex_en        = 1'b1;
        exmem_en       = 1'b1;
        memwb_en       = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        memwb_bubble   = 1'b0;
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        if (reset) begin
            pc_en          = 1'b0;
            ifid_en        = 1'b0;
            idex_en        = 1'b0;
            exmem_en       = 1'b0;
            memwb_en       = 1'b0;
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            memwb_bubble   = 1'b1;
            w_state_nxt    = RUN;
            w_wait_cnt_nxt = 8'd0;
        end else begin
            case (r_state)
                RUN, MEM_WAIT: begin
                    if (w_mem_stall) begin
                        pc_en          = 1'b0;
                        ifid_en        = 1'b0;
                        idex_en        = 1'b0;
                        exmem_en       = 1'b0;
                        memwb_bubble   = 1'b1;
                        w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                        if ((r_state == MEM_WAIT) && (r_wait_cnt == TIMEOUT_LAST)) begin
                            w_state_nxt = ERR;
                        end else begin
                            w_state_nxt = MEM_WAIT;
                        end
                    end else begin
                        // The ready cycle behaves exactly like a RUN cycle.
                        w_state_nxt    = RUN;
                        w_wait_cnt_nxt = 8'd0;
                        if (ex_br_taken) begin
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                        end else if (w_hazard) begin
                            pc_en      = 1'b0;
                            ifid_en    = 1'b0;
                            idex_flush = 1'b1;
                        end else begin
                            idex_flush = 1'b0;
                        end
                    end
                end
                ERR: begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_en     = 1'b0;
                    memwb_bubble = 1'b1;
                    w_state_nxt  = ERR;
                end
                default: begin
                    pc_en          = 1'b0;
                    ifid_en        = 1'b0;
                    idex_en        = 1'b0;
                    exmem_en       = 1'b0;
                    memwb_en       = 1'b0;
                    memwb_bubble   = 1'b1;
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = 8'd0;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_EN
    logic        w_active;
    logic        w_stall_evt;
    logic        w_flush_evt;
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    assign w_active    = (r_state == RUN) | (r_state == MEM_WAIT);
    assign w_stall_evt = (r_state == ERR) |
                         (w_active & (w_mem_stall | (~ex_br_taken & w_hazard)));
    assign w_flush_evt = w_active & ~w_mem_stall & ex_br_taken;

    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= 32'd0;
            r_flush_events <= 32'd0;
        end else begin
            if (w_stall_evt && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_flush_evt && (r_flush_events != 32'hFFFF_FFFF)) begin
                r_flush_events <= r_flush_events + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`else
    assign stall_cycles = 32'd0;
    assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed test-plan steps then random traffic
// against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int MT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rn, id_rm, ex_rd;
    logic        id_rn_used, id_rm_used, id_flag_use;
    logic        ex_mem_read, ex_flag_write, ex_br_taken;
    logic        mem_valid, mem_ready;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, memwb_bubble, mem_timeout;
    logic [31:0] stall_cycles, flush_events;

    int checks = 0;
    int failures = 0;

    // Model: error latch, consecutive memory-stall count, perf counts.
    bit          m_err;
    int          m_run;
    longint      m_stalls;
    longint      m_flushes;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MT)) dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
        .id_flag_use(id_flag_use), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_flag_write(ex_flag_write), .ex_br_taken(ex_br_taken),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hz_lu();
        return ex_mem_read && (ex_rd != 5'd31) &&
               ((id_rn_used && id_rn == ex_rd) || (id_rm_used && id_rm == ex_rd));
    endfunction

    function automatic bit hz_any();
        return hz_lu() || (id_flag_use && ex_flag_write);
    endfunction

    function automatic bit mstall();
        return mem_valid && !mem_ready;
    endfunction

    // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, memwb_bubble}
    function automatic logic [7:0] exp_vec();
        if (reset)              return 8'b00000_111;
        else if (m_err)         return 8'b00000_001;
        else if (mstall())      return 8'b00001_001;
        else if (ex_br_taken)   return 8'b11111_110;
        else if (hz_any())      return 8'b00111_010;
        else                    return 8'b11111_000;
    endfunction

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_ctl"}, {24'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                           ifid_flush, idex_flush, memwb_bubble}, {24'd0, exp_vec()});
        chk({tag, "_tmo"}, {31'd0, mem_timeout}, {31'd0, (m_err && !reset)});
`ifdef PIPE_PERF_EN
        chk({tag, "_stc"}, stall_cycles, sat32(m_stalls));
        chk({tag, "_fle"}, flush_events, sat32(m_flushes));
`else
        chk({tag, "_stc"}, stall_cycles, 32'd0);
        chk({tag, "_fle"}, flush_events, 32'd0);
`endif
    endtask

    task automatic model_update();
        if (reset) begin
            m_err = 1'b0; m_run = 0; m_stalls = 0; m_flushes = 0;
        end else if (m_err) begin
            m_stalls++;
        end else if (mstall()) begin
            m_stalls++;
            m_run++;
            if (m_run == MT) m_err = 1'b1;
        end else begin
            m_run = 0;
            if (ex_br_taken) m_flushes++;
            else if (hz_any()) m_stalls++;
        end
    endtask

    task automatic step(input string tag);
        #2;
        check_all(tag);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rn = 5'd0; id_rm = 5'd0; ex_rd = 5'd0;
        id_rn_used = 1'b0; id_rm_used = 1'b0; id_flag_use = 1'b0;
        ex_mem_read = 1'b0; ex_flag_write = 1'b0; ex_br_taken = 1'b0;
        mem_valid = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        ex_mem_read = 1'b1; ex_rd = rd;
        id_rn = rn; id_rn_used = 1'b1;
        id_rm = rm; id_rm_used = 1'b1;
    endtask

    initial begin
        m_err = 1'b0; m_run = 0; m_stalls = 0; m_flushes = 0;
        reset = 1'b1;
        idle();
        step("rst0");
        step("rst1");
        reset = 1'b0;
        step("idle");

        set_lu(5'd2, 5'd1, 5'd2);
        step("lu");
        idle();
        step("lu_after");
        set_lu(5'd31, 5'd1, 5'd31);
        step("xzr");
        set_lu(5'd2, 5'd3, 5'd5);
        step("indep");
        idle();
        ex_flag_write = 1'b1; id_flag_use = 1'b1;
        step("flag");
        idle();
        step("flag_after");
        set_lu(5'd2, 5'd1, 5'd2);
        ex_br_taken = 1'b1;
        step("br_lu");
        idle();

        mem_valid = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("mwait");
        mem_ready = 1'b1;
        step("mready");
        idle();
        step("mdone");

        mem_valid = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < MT; i++) step("tmo_wait");
        step("err0");
        ex_br_taken = 1'b1; mem_valid = 1'b0;
        set_lu(5'd4, 5'd4, 5'd0);
        step("err1");
        idle();
        reset = 1'b1;
        step("err_rst");
        reset = 1'b0;
        step("err_rel");

        mem_valid = 1'b1; mem_ready = 1'b0;
        step("mw_pre");
        #2;
        reset = 1'b1;
        #1;
        check_all("mid_rst");
        model_update();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        step("post_rst");

        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 99) < 3);
            id_rn         = 5'($urandom_range(0, 7));
            id_rm         = 5'($urandom_range(0, 7));
            ex_rd         = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            id_rn_used    = 1'($urandom_range(0, 1));
            id_rm_used    = 1'($urandom_range(0, 1));
            id_flag_use   = 1'($urandom_range(0, 1));
            ex_mem_read   = 1'($urandom_range(0, 1));
            ex_flag_write = 1'($urandom_range(0, 1));
            ex_br_taken   = ($urandom_range(0, 3) == 0);
            mem_valid     = ($urandom_range(0, 2) == 0);
            mem_ready     = ($urandom_range(0, 9) < 6);
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
